// File: rtl/attn_ctrl_pkg.sv
// Shared types and default sizing for the attention-core sequencer.
package attn_ctrl_pkg;

  localparam int unsigned N_ROWS_DEF = 8;
  localparam int unsigned N_KEYS_DEF = 8;
  localparam int unsigned CORES_DEF  = 2;
  localparam int unsigned WDT_W_DEF  = 8;

  // Encoding is visible on the debug state port, so keep it stable.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'h0,
    ST_LOAD_Q  = 4'h1,
    ST_LOAD_K  = 4'h2,
    ST_PRELOAD = 4'h3,
    ST_EXEC    = 4'h4,
    ST_DRAIN   = 4'h5,
    ST_SFP_ACC = 4'h6,
    ST_SFP_DIV = 4'h7,
    ST_DONE    = 4'h8,
    ST_ERR     = 4'hF
  } state_e;

endpackage

// File: rtl/attn_row_cnt.sv
// Row counter shared by the issue and drain phases; saturates at the last row.
module attn_row_cnt
  import attn_ctrl_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !last_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == last_i);

endmodule

// File: rtl/attn_seq_ctrl.sv
// Handshake-driven sequencer for one Q*K attention pass, with multi-core SFP
// sync and a per-phase stall watchdog.
module attn_seq_ctrl
  import attn_ctrl_pkg::*;
#(
  parameter int unsigned N_ROWS = N_ROWS_DEF,
  parameter int unsigned N_KEYS = N_KEYS_DEF,
  parameter int unsigned CORES  = CORES_DEF,
  parameter int unsigned WDT_W  = WDT_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(N_ROWS+1)-1:0]   n_rows,
  input  logic                          q_full,
  input  logic                          k_full,
  input  logic                          ld_done,
  input  logic                          ofifo_valid,
  input  logic [CORES-1:0]              sfp_ready,
  input  logic                          int_fifo_full,
  output logic                          q_wr,
  output logic                          k_wr,
  output logic                          kmem_ld,
  output logic                          exec,
  output logic                          ofifo_rd,
  output logic                          sfp_acc,
  output logic                          sfp_div,
  output logic [$clog2(N_ROWS)-1:0]     row_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [3:0]                    state
);

  localparam int unsigned CNT_W  = $clog2(N_ROWS + 1);
  localparam int unsigned RIDX_W = $clog2(N_ROWS);
  localparam logic [RIDX_W-1:0] LAST_MAX = RIDX_W'(N_ROWS - 1);

  if (N_ROWS < 2 || N_KEYS < 1 || CORES < 1 || WDT_W < 2) begin : g_bad_params
    $error("attn_seq_ctrl: unsupported parameter set");
  end

  state_e            state_q, state_d;
  logic [RIDX_W-1:0] last_row_q, last_row_d;
  logic [WDT_W-1:0]  wdt_q, wdt_d;
  logic              q_wr_q, k_wr_q, kmem_ld_q, exec_q, exec_d;
  logic              sfp_acc_q, sfp_div_q, busy_q, done_q, err_q;
  logic              start_ok, pop, wdt_exp;
  logic [RIDX_W-1:0] ex_cnt, dr_cnt;
  logic              ex_last, dr_last;

  assign start_ok = (state_q == ST_IDLE) && start;
  assign pop      = (state_q == ST_DRAIN) && ofifo_valid && !int_fifo_full;
  assign wdt_exp  = (wdt_q == '1) && (state_q != ST_IDLE) && (state_q != ST_ERR);

  // The last row index is stored rather than the count, so it fits row_idx width.
  always_comb begin
    last_row_d = last_row_q;
    if (start_ok) begin
      if (n_rows == '0 || n_rows > CNT_W'(N_ROWS))
        last_row_d = LAST_MAX;
      else
        last_row_d = RIDX_W'(n_rows - 1'b1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start)                state_d = ST_LOAD_Q;
      ST_LOAD_Q:  if (q_full)               state_d = ST_LOAD_K;
      ST_LOAD_K:  if (k_full)               state_d = ST_PRELOAD;
      ST_PRELOAD: if (ld_done)              state_d = ST_EXEC;
      ST_EXEC:    if (exec_q && ex_last)    state_d = ST_DRAIN;
      ST_DRAIN:   if (pop && dr_last)       state_d = ST_SFP_ACC;
      ST_SFP_ACC: if (&sfp_ready)           state_d = ST_SFP_DIV;
      ST_SFP_DIV:                           state_d = ST_DONE;
      ST_DONE:                              state_d = ST_IDLE;
      ST_ERR:                               state_d = ST_ERR;
      default:                              state_d = ST_IDLE;
    endcase
    if (wdt_exp)
      state_d = ST_ERR;
  end

  // Any forward progress (phase change or accepted row beat) restarts the watchdog.
  always_comb begin
    if (state_d != state_q || exec_q || pop || state_q == ST_IDLE || state_q == ST_ERR)
      wdt_d = '0;
    else
      wdt_d = wdt_q + 1'b1;
  end

  assign exec_d = (state_d == ST_EXEC) && !int_fifo_full;

  attn_row_cnt #(.W(RIDX_W)) u_exec_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (start_ok),
    .inc_i  (exec_q),
    .last_i (last_row_q),
    .cnt_o  (ex_cnt),
    .last_o (ex_last)
  );

  attn_row_cnt #(.W(RIDX_W)) u_drain_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (start_ok),
    .inc_i  (pop),
    .last_i (last_row_q),
    .cnt_o  (dr_cnt),
    .last_o (dr_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_row_q <= LAST_MAX;
      wdt_q      <= '0;
      q_wr_q     <= 1'b0;
      k_wr_q     <= 1'b0;
      kmem_ld_q  <= 1'b0;
      exec_q     <= 1'b0;
      sfp_acc_q  <= 1'b0;
      sfp_div_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_row_q <= last_row_d;
      wdt_q      <= wdt_d;
      q_wr_q     <= (state_d == ST_LOAD_Q);
      k_wr_q     <= (state_d == ST_LOAD_K);
      kmem_ld_q  <= (state_d == ST_PRELOAD);
      exec_q     <= exec_d;
      sfp_acc_q  <= (state_d == ST_SFP_ACC);
      sfp_div_q  <= (state_d == ST_SFP_DIV);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      err_q      <= err_q | (state_d == ST_ERR);
    end
  end

  assign q_wr     = q_wr_q;
  assign k_wr     = k_wr_q;
  assign kmem_ld  = kmem_ld_q;
  assign exec     = exec_q;
  assign ofifo_rd = pop;
  assign sfp_acc  = sfp_acc_q;
  assign sfp_div  = sfp_div_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign state    = state_q;
  assign row_idx  = (state_q == ST_EXEC)  ? ex_cnt :
                    (state_q == ST_DRAIN) ? dr_cnt : '0;

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// Scenario bench for attn_seq_ctrl with a scoreboard of expected row indices.
module tb_attn_seq_ctrl;
  import attn_ctrl_pkg::*;

  localparam int N_ROWS = 8;
  localparam int N_KEYS = 8;
  localparam int CORES  = 2;
  localparam int WDT_W  = 8;
  localparam int CNT_W  = $clog2(N_ROWS + 1);
  localparam int RIDX_W = $clog2(N_ROWS);

  typedef logic [RIDX_W-1:0] ridx_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  n_rows = '0;
  logic              q_full = 1'b0, k_full = 1'b0, ld_done = 1'b0;
  logic              ofifo_valid = 1'b0, int_fifo_full = 1'b0;
  logic [CORES-1:0]  sfp_ready = '0;
  logic              q_wr, k_wr, kmem_ld, exec, ofifo_rd, sfp_acc, sfp_div;
  logic              busy, done, err;
  ridx_t             row_idx;
  logic [3:0]        state;

  always #5 clk = ~clk;

  attn_seq_ctrl #(.N_ROWS(N_ROWS), .N_KEYS(N_KEYS), .CORES(CORES), .WDT_W(WDT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .n_rows(n_rows),
    .q_full(q_full), .k_full(k_full), .ld_done(ld_done), .ofifo_valid(ofifo_valid),
    .sfp_ready(sfp_ready), .int_fifo_full(int_fifo_full),
    .q_wr(q_wr), .k_wr(k_wr), .kmem_ld(kmem_ld), .exec(exec), .ofifo_rd(ofifo_rd),
    .sfp_acc(sfp_acc), .sfp_div(sfp_div), .row_idx(row_idx), .busy(busy),
    .done(done), .err(err), .state(state)
  );

  int    checks = 0;
  int    errors = 0;
  ridx_t exp_exec[$];
  ridx_t exp_pop[$];
  int    avail, n_exec, n_pop, n_div, n_done;
  int    n_cyc[16];
  bit    lb_q = 1'b1;
  logic  ff_v = 1'b0;
  logic [CORES-1:0] sr_v = '1;

  // One clock: registered outputs observed at +1, bench model drives inputs, ofifo_rd at +2.
  task automatic step();
    ridx_t e;
    @(posedge clk);
    #1;
    n_cyc[state] = n_cyc[state] + 1;
    if (sfp_div) n_div++;
    if (done) n_done++;
    if (exec) begin
      n_exec++;
      avail++;
      checks++;
      if (exp_exec.size() == 0) begin
        errors++;
        $display("FAIL exec_extra got beat row_idx=%0d want no beat", row_idx);
      end else begin
        e = exp_exec.pop_front();
        if (row_idx !== e) begin
          errors++;
          $display("FAIL exec_row got %0d want %0d", row_idx, e);
        end
      end
    end
    q_full        = lb_q & q_wr;
    k_full        = k_wr;
    ld_done       = kmem_ld;
    ofifo_valid   = (avail > 0);
    int_fifo_full = ff_v;
    sfp_ready     = sr_v;
    #1;
    if (ofifo_rd) begin
      n_pop++;
      avail--;
      checks++;
      if (exp_pop.size() == 0) begin
        errors++;
        $display("FAIL pop_extra got pop row_idx=%0d want no pop", row_idx);
      end else begin
        e = exp_pop.pop_front();
        if (row_idx !== e) begin
          errors++;
          $display("FAIL pop_row got %0d want %0d", row_idx, e);
        end
      end
    end
  endtask

  task automatic clear_counts();
    n_exec = 0; n_pop = 0; n_div = 0; n_done = 0;
    for (int i = 0; i < 16; i++) n_cyc[i] = 0;
  endtask

  task automatic flush_model();
    exp_exec.delete();
    exp_pop.delete();
    avail = 0;
  endtask

  task automatic start_pass(input int n, input int rows);
    start  = 1'b1;
    n_rows = CNT_W'(n);
    for (int i = 0; i < rows; i++) begin
      exp_exec.push_back(ridx_t'(i));
      exp_pop.push_back(ridx_t'(i));
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({q_wr, k_wr, kmem_ld, exec, ofifo_rd, sfp_acc, sfp_div, busy, done, err} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {q_wr, k_wr, kmem_ld, exec, ofifo_rd, sfp_acc, sfp_div, busy, done, err});
    end
    checks++;
    if (state !== 4'h0 || row_idx !== '0) begin
      errors++;
      $display("FAIL reset_state got state=%0h row=%0d want 0/0", state, row_idx);
    end
    reset = 1'b0;
    step();
    checks++;
    if (state !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got state=%0h busy=%b want 0/0", state, busy);
    end
  endtask

  task automatic test_nominal();
    bit to;
    clear_counts(); flush_model();
    sr_v = '1; ff_v = 1'b0; lb_q = 1'b1;
    start_pass(8, 8);
    wait_done(200, to);
    checks++;
    if (to) begin errors++; $display("FAIL nominal_timeout got no done want done"); end
    checks++;
    if (n_exec != 8 || n_pop != 8 || n_div != 1) begin
      errors++;
      $display("FAIL nominal_counts got exec=%0d pop=%0d div=%0d want 8/8/1", n_exec, n_pop, n_div);
    end
    checks++;
    if (n_cyc[ST_EXEC] != 8) begin errors++; $display("FAIL nominal_exec_len got %0d want 8", n_cyc[ST_EXEC]); end
    checks++;
    if (exp_exec.size() + exp_pop.size() != 0) begin
      errors++;
      $display("FAIL nominal_leftover got %0d want 0", exp_exec.size() + exp_pop.size());
    end
    checks++;
    if (busy !== 1'b1 || state !== ST_DONE) begin
      errors++;
      $display("FAIL nominal_done_cycle got busy=%b state=%0h want 1/8", busy, state);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL nominal_idle got busy=%b done=%b state=%0h want 0/0/0", busy, done, state);
    end
  endtask

  task automatic test_exec_stall();
    bit to;
    int stalls;
    clear_counts(); flush_model();
    sr_v = '1; ff_v = 1'b0;
    stalls = 0;
    start_pass(3, 3);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (exec) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin errors++; $display("FAIL stall_first_beat got none want beat"); end
    ff_v = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 4) ff_v = 1'b0;
      step();
      if (state !== ST_EXEC) break;
      if (!exec) begin
        stalls++;
        checks++;
        if (row_idx !== ridx_t'(n_exec)) begin
          errors++;
          $display("FAIL stall_row_hold got %0d want %0d", row_idx, n_exec);
        end
      end
    end
    ff_v = 1'b0;
    wait_done(100, to);
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout got no done want done"); end
    checks++;
    if (n_exec != 3 || n_cyc[ST_EXEC] != 7 || stalls != 4) begin
      errors++;
      $display("FAIL stall_counts got exec=%0d len=%0d stalls=%0d want 3/7/4", n_exec, n_cyc[ST_EXEC], stalls);
    end
    checks++;
    if (n_pop != 3 || exp_pop.size() != 0) begin
      errors++;
      $display("FAIL stall_pops got %0d want 3", n_pop);
    end
    step();
  endtask

  task automatic test_sfp_partial();
    logic [CORES-1:0] pats [3];
    bit to;
    pats[0] = 2'b01; pats[1] = 2'b10; pats[2] = 2'b01;
    clear_counts(); flush_model();
    sr_v = '0; ff_v = 1'b0;
    start_pass(2, 2);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (state === ST_SFP_ACC) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin errors++; $display("FAIL sfp_reach got state=%0h want 6", state); end
    for (int p = 0; p < 3; p++) begin
      sr_v = pats[p];
      step();
      checks++;
      if (state !== ST_SFP_ACC || sfp_acc !== 1'b1 || sfp_div !== 1'b0) begin
        errors++;
        $display("FAIL sfp_wait_%0d got state=%0h acc=%b div=%b want 6/1/0", p, state, sfp_acc, sfp_div);
      end
    end
    sr_v = '1;
    step();
    checks++;
    if (state !== ST_SFP_ACC || sfp_acc !== 1'b1) begin
      errors++;
      $display("FAIL sfp_last_partial got state=%0h acc=%b want 6/1", state, sfp_acc);
    end
    step();
    checks++;
    if (state !== ST_SFP_DIV || sfp_div !== 1'b1 || sfp_acc !== 1'b0) begin
      errors++;
      $display("FAIL sfp_div_cycle got state=%0h div=%b acc=%b want 7/1/0", state, sfp_div, sfp_acc);
    end
    sr_v = '0;
    step();
    checks++;
    if (state !== ST_DONE || done !== 1'b1 || sfp_div !== 1'b0 || n_div != 1) begin
      errors++;
      $display("FAIL sfp_done got state=%0h done=%b div=%b ndiv=%0d want 8/1/0/1", state, done, sfp_div, n_div);
    end
    step();
    sr_v = '1;
  endtask

  task automatic test_watchdog();
    bit to;
    clear_counts(); flush_model();
    lb_q = 1'b0; sr_v = '1;
    start_pass(8, 8);
    exp_exec.delete(); exp_pop.delete();
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (err === 1'b1) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin errors++; $display("FAIL wdt_timeout got err=%b want 1", err); end
    checks++;
    if (n_cyc[ST_LOAD_Q] != 256) begin
      errors++;
      $display("FAIL wdt_len got %0d want 256", n_cyc[ST_LOAD_Q]);
    end
    checks++;
    if (state !== 4'hF || busy !== 1'b1 || {q_wr, k_wr, kmem_ld, exec, ofifo_rd, sfp_acc, sfp_div, done} !== 8'b0) begin
      errors++;
      $display("FAIL wdt_err_state got state=%0h busy=%b want F/1 strobes 0", state, busy);
    end
    start = 1'b1; n_rows = CNT_W'(3);
    step();
    start = 1'b0;
    step(); step(); step();
    checks++;
    if (state !== 4'hF || err !== 1'b1) begin
      errors++;
      $display("FAIL wdt_sticky got state=%0h err=%b want F/1", state, err);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (state !== 4'h0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wdt_reset got state=%0h err=%b busy=%b want 0/0/0", state, err, busy);
    end
    lb_q = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_drain();
    bit to;
    clear_counts(); flush_model();
    sr_v = '1; ff_v = 1'b0;
    start_pass(8, 8);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (n_pop == 2) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin errors++; $display("FAIL rst_drain_reach got pops=%0d want 2", n_pop); end
    reset = 1'b1;
    step();
    checks++;
    if ({q_wr, k_wr, kmem_ld, exec, ofifo_rd, sfp_acc, sfp_div, busy, done, err} !== 10'b0
        || state !== 4'h0 || row_idx !== '0) begin
      errors++;
      $display("FAIL rst_drain_outputs got state=%0h row=%0d busy=%b want all 0", state, row_idx, busy);
    end
    reset = 1'b0;
    flush_model();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (n_done != 0 || state !== 4'h0) begin
      errors++;
      $display("FAIL rst_drain_no_done got done=%0d state=%0h want 0/0", n_done, state);
    end
    clear_counts();
    start_pass(8, 8);
    wait_done(200, to);
    checks++;
    if (to || n_exec != 8 || n_pop != 8) begin
      errors++;
      $display("FAIL rst_drain_fresh got to=%b exec=%0d pop=%0d want 0/8/8", to, n_exec, n_pop);
    end
    step();
  endtask

  task automatic test_busy_start_zero();
    bit to;
    clear_counts(); flush_model();
    sr_v = '1; ff_v = 1'b0;
    start_pass(0, 8);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (exec) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin errors++; $display("FAIL zero_first_beat got none want beat"); end
    start = 1'b1; n_rows = CNT_W'(3);
    step();
    start = 1'b0;
    wait_done(200, to);
    checks++;
    if (to || n_exec != 8 || n_pop != 8 || exp_exec.size() + exp_pop.size() != 0) begin
      errors++;
      $display("FAIL zero_rows got to=%b exec=%0d pop=%0d want 0/8/8", to, n_exec, n_pop);
    end
    step(); step(); step();
    checks++;
    if (state !== 4'h0 || busy !== 1'b0 || n_cyc[ST_LOAD_Q] != 1) begin
      errors++;
      $display("FAIL busy_start_ignored got state=%0h busy=%b loadq=%0d want 0/0/1", state, busy, n_cyc[ST_LOAD_Q]);
    end
  endtask

  initial begin
    avail = 0;
    clear_counts();
    test_reset();
    test_nominal();
    test_exec_stall();
    test_sfp_partial();
    test_watchdog();
    test_reset_mid_drain();
    test_busy_start_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/attn_seq_ctrl.md
Name: attn_seq_ctrl

Overview:
Parametrised next-generation sequencer for the attention core. It steps through a full Q·K pass: Q load, K load, array pre-load, execute, OFIFO drain, SFP normalisation. Each phase ends on a completion handshake rather than a fixed timing. Sits between the top-level start/done interface and the SRAM/array/OFIFO/SFP datapath, and replaces the fixed 19-bit instruction-word controller with discrete strobes, runtime row count, multi-core sync and a watchdog.

Parameters:
N_ROWS, 8, maximum Q rows (and output rows) per pass
N_KEYS, 8, K vectors pre-loaded into the array
CORES, 2, number of cores whose sfp_ready must all assert before normalisation
WDT_W, 8, watchdog counter width; a phase stalled for 2^WDT_W cycles raises err

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE
n_rows  in  $clog2(N_ROWS+1)  rows this pass; sampled on accepted start; 0 treated as N_ROWS
q_full  in  1  Q memory write complete
k_full  in  1  K memory write complete
ld_done  in  1  array K pre-load complete
ofifo_valid  in  1  OFIFO holds at least one output row
sfp_ready  in  CORES  per-core SFP sum ready
int_fifo_full  in  1  inter-core FIFO full (backpressure)
q_wr  out  1  Q memory write enable
k_wr  out  1  K memory write enable
kmem_ld  out  1  array pre-load enable
exec  out  1  issue one Q row into the array
ofifo_rd  out  1  pop one OFIFO row
sfp_acc  out  1  SFP accumulate strobe
sfp_div  out  1  SFP divide strobe
row_idx  out  $clog2(N_ROWS)  current row address for exec/ofifo_rd
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on DONE entry
err  out  1  sticky watchdog error; cleared only by reset
state  out  4  encoded FSM state, for debug

Behaviour:
- Reset (synchronous): state=IDLE; every output 0; row_idx=0; counters cleared; captured n_rows = N_ROWS. A reset in mid-operation aborts the pass on the next edge, and no done is issued.
- States: IDLE→LOAD_Q→LOAD_K→PRELOAD→EXEC→DRAIN→SFP_ACC→SFP_DIV→DONE→IDLE. Any phase goes to ERR when the watchdog expires. ERR is held until reset.
- IDLE: start=1 captures n_rows and enters LOAD_Q on the next cycle. Start is ignored in every other state.
- LOAD_Q: q_wr=1 until the cycle q_full is sampled high, then go to LOAD_K. LOAD_K and PRELOAD behave the same way, using k_wr/k_full and kmem_ld/ld_done.
- EXEC:
  - exec=1 for exactly n_rows cycles, with row_idx 0..n_rows-1.
  - exec is held at 0 (row_idx frozen) while int_fifo_full=1.
  - After the last issue, go to DRAIN.
- DRAIN:
  - ofifo_rd = ofifo_valid & ~int_fifo_full.
  - row_idx counts accepted pops from 0.
  - After n_rows pops, go to SFP_ACC.
  - Pops never exceed n_rows, even if ofifo_valid stays high.
- SFP_ACC: sfp_acc=1 while waiting. Leave when &sfp_ready (all CORES bits high in the same cycle); a partial ready does not advance.
- SFP_DIV: sfp_div=1 for exactly one cycle, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy deasserts in the IDLE cycle.
- Watchdog: cleared on every state change and on every accepted exec/ofifo_rd beat. Otherwise it increments; at the all-ones value the next state is ERR and err=1. In ERR all strobes are 0 and busy=1.
- Handshake inputs are level-sampled. A completion signal already high on state entry advances after one strobe cycle, so the minimum phase length is 1 cycle.
- Outputs are registered from the state and counters; there is no combinational input→output path except ofifo_rd.

Decomposition:
- Package attn_ctrl_pkg holds the state enum (4-bit encoding, IDLE=0, ERR=4'hF) and the default parameter constants.
- One sub-module: attn_row_cnt, a loadable up-counter with terminal-count compare, instantiated for both EXEC and DRAIN.
- The watchdog is kept inline.

Test Plan:
- Nominal pass, n_rows=8, bench loopback of q_full/k_full/ld_done one cycle after strobe → 8 exec beats with row_idx 0..7, 8 pops, one sfp_div, done pulse, busy low the following cycle.
- n_rows=3, int_fifo_full high for 4 cycles mid-EXEC → exactly 3 exec beats, row_idx held for those 4 cycles, total EXEC length 7 cycles.
- CORES=2, sfp_ready toggles 01, 10, 01 then 11 → stays in SFP_ACC until 11, then exactly one sfp_div cycle.
- q_full never asserted → err=1 after 256 cycles (WDT_W=8), state=4'hF; a later start is ignored; reset returns to IDLE with err=0.
- Reset asserted during DRAIN after 2 pops → next cycle state=IDLE and all outputs 0; no done pulse; a fresh start runs a full pass.
- start pulsed while busy, and n_rows=0 → start ignored; the 0 value produces 8 rows (N_ROWS).
